// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the rotate-right barrel shifter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package barrel_shifter_pkg;

  // Default data width and the rotate-amount width that addresses it.
  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_SHAMT_W = 3;

endpackage : barrel_shifter_pkg

// File: rtl/barrel_shifter_if.sv
// Data/amount/result bundle for the barrel shifter.
// Latency: n/a (wires only).
// Backpressure: none, no handshake; every cycle carries a new operation.
interface barrel_shifter_if
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
);

  logic [WIDTH-1:0]   i_A;
  logic [SHAMT_W-1:0] i_k;
  logic [WIDTH-1:0]   o_Y;

  // Requester side: supplies word and amount, observes the result.
  modport master (
    output i_A,
    output i_k,
    input  o_Y
  );

  // Shifter side: consumes word and amount, produces the result.
  modport slave (
    input  i_A,
    input  i_k,
    output o_Y
  );

endinterface : barrel_shifter_if

// File: rtl/barrel_shifter_stage.sv
// One conditional rotate-right-by-DIST stage of the logarithmic shifter.
// Latency: purely combinational.
// Backpressure: none.
module barrel_shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  // Low DIST bits wrap around to the top; nothing is dropped or zero-filled.
  logic [WIDTH-1:0] rotated;

  assign rotated = {din[DIST-1:0], din[WIDTH-1:DIST]};
  assign dout    = en ? rotated : din;

endmodule : barrel_shifter_stage

// File: rtl/barrel_shifter.sv
// Rotate-right barrel shifter: o_Y = i_A rotated right by i_k.
// Latency: 1 cycle, fully pipelined, one operation per cycle.
// Backpressure: none; inputs are sampled on every rising edge.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  barrel_shifter_if.slave   bus
);

  // Stage s rotates by 2^s when amount bit s is set. Each stage keeps its
  // own local nets so the chain is a plain feed-forward cascade.
  for (genvar s = 0; s < SHAMT_W; s++) begin : gen_stage
    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] stage_out;

    if (s == 0) begin : g_first
      assign stage_in = bus.i_A;
    end else begin : g_chain
      assign stage_in = gen_stage[s-1].stage_out;
    end

    barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << s)
    ) u_stage (
      .din  (stage_in),
      .en   (bus.i_k[s]),
      .dout (stage_out)
    );
  end

  logic [WIDTH-1:0] rot_dat;
  logic [WIDTH-1:0] y_q;

  assign rot_dat = gen_stage[SHAMT_W-1].stage_out;

  // Output register; reset wins over capture and discards any in-flight result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_q <= '0;
    end else begin
      y_q <= rot_dat;
    end
  end

  assign bus.o_Y = y_q;

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter with a queue-based scoreboard.
// Latency: expects each result one cycle after its inputs are sampled.
// Backpressure: none; stimulus is applied every cycle.
module tb_barrel_shifter;

  localparam int W  = 8;
  localparam int KW = 3;

  typedef struct {
    logic [W-1:0] val;
    string        tag;
  } exp_t;

  logic i_clk;
  logic i_rst;

  barrel_shifter_if #(.WIDTH(W), .SHAMT_W(KW)) bus ();

  barrel_shifter #(.WIDTH(W), .SHAMT_W(KW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: bit j of the result is a[(j + k) mod W].
  function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] a, input int k);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) begin
      r[j] = a[(j + k) % W];
    end
    return r;
  endfunction

  // Drive one operation for the next rising edge and record what it must yield.
  task automatic apply(input logic [W-1:0] a, input logic [KW-1:0] k,
                       input logic rst, input logic [W-1:0] expv, input string tag);
    exp_t e;
    @(negedge i_clk);
    bus.i_A = a;
    bus.i_k = k;
    i_rst   = rst;
    e.val   = expv;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge that has a pending expectation is checked just after it.
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.o_Y !== e.val) begin
        n_fail++;
        $display("FAIL %s: o_Y=%02h expected %02h", e.tag, bus.o_Y, e.val);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    int           waited;

    bus.i_A = '0;
    bus.i_k = '0;
    i_rst   = 1'b1;

    // Reset state, including reset overriding live data.
    apply(8'h00, 3'd0, 1'b1, 8'h00, "reset_idle");
    apply(8'hA7, 3'd5, 1'b1, 8'h00, "reset_priority");

    // Directed rotations of 0xB4.
    apply(8'hB4, 3'd0, 1'b0, 8'hB4, "rot0_B4");
    apply(8'hB4, 3'd1, 1'b0, 8'h5A, "rot1_B4");
    apply(8'hB4, 3'd3, 1'b0, 8'h96, "rot3_B4");
    apply(8'hB4, 3'd4, 1'b0, 8'h4B, "rot4_B4");
    apply(8'hB4, 3'd7, 1'b0, 8'h69, "rot7_B4");
    apply(8'h01, 3'd7, 1'b0, 8'h02, "rot7_01");

    // Random sweep over every amount.
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 10; n++) begin
        a = W'($urandom_range(0, 255));
        apply(a, KW'(k), 1'b0, ref_rotr(a, k), $sformatf("sweep_k%0d", k));
      end
    end

    // All-ones and all-zeros are rotation invariant.
    for (int k = 0; k < 8; k++) begin
      apply(8'hFF, KW'(k), 1'b0, 8'hFF, $sformatf("inv_ff_k%0d", k));
      apply(8'h00, KW'(k), 1'b0, 8'h00, $sformatf("inv_00_k%0d", k));
    end

    // Reset pulse in the middle of a steady stream.
    apply(8'hB4, 3'd1, 1'b0, 8'h5A, "mid_pre");
    apply(8'hB4, 3'd1, 1'b1, 8'h00, "mid_reset_edge");
    apply(8'hB4, 3'd1, 1'b0, 8'h5A, "mid_after_release");

    // Back-to-back changes.
    apply(8'h81, 3'd1, 1'b0, 8'hC0, "b2b_first");
    apply(8'h81, 3'd2, 1'b0, 8'h60, "b2b_second");

    // Bounded drain of the scoreboard.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge i_clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_barrel_shifter
